// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle control sequencer for the 24-bit CPU
// Optional undefined-opcode trap: define CPU_SEQ_ILLEGAL_TRAP_EN.
module cpu_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [3:0]       OPCODE,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PcWrite,
  output logic             IrWrite,
  output logic             PcSrc,
  output logic             RegDst,
  output logic             Branch,
  output logic             MemRead,
  output logic             MemToReg,
  output logic             MemWrite,
  output logic             AluSrc,
  output logic             RegWrite,
  output logic [1:0]       AluOp,
  output logic             InstrDone,
  output logic             Illegal,
  output logic [2:0]       State,
  output logic [CNT_W-1:0] RetiredCount
);

  typedef enum logic [2:0] {
    sIdle   = 3'd0,
    sFetch  = 3'd1,
    sDecode = 3'd2,
    sExec   = 3'd3,
    sMem    = 3'd4,
    sWb     = 3'd5,
    sTrap   = 3'd7
  } seqState;

  localparam logic [3:0] opNop  = 4'b0000;
  localparam logic [3:0] opAddi = 4'b0001;
  localparam logic [3:0] opLs   = 4'b0010;
  localparam logic [3:0] opSs   = 4'b0011;
  localparam logic [3:0] opBeq  = 4'b0100;
  localparam logic [3:0] opR    = 4'b0110;
  localparam logic [3:0] opMul  = 4'b0111;

  seqState    stateQ, stateNext;
  logic [3:0] opQ;

  function automatic logic isDefined(input logic [3:0] op);
    return (op == opNop) || (op == opAddi) || (op == opLs) || (op == opSs) ||
           (op == opBeq) || (op == opR) || (op == opMul);
  endfunction

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stateQ       <= sIdle;
      opQ          <= 4'b0000;
      RetiredCount <= '0;
    end else begin
      stateQ <= stateNext;
      if (stateQ == sDecode) opQ <= OPCODE;
      if (InstrDone) RetiredCount <= RetiredCount + CNT_W'(1);
    end
  end

  // Outputs are decoded from the registered state, so an asynchronous reset
  // drops every control line immediately without waiting for a clock edge.
  always_comb begin
    stateNext = stateQ;
    PcWrite   = 1'b0;
    IrWrite   = 1'b0;
    PcSrc     = 1'b0;
    RegDst    = 1'b0;
    Branch    = 1'b0;
    MemRead   = 1'b0;
    MemToReg  = 1'b0;
    MemWrite  = 1'b0;
    AluSrc    = 1'b0;
    RegWrite  = 1'b0;
    AluOp     = 2'b00;
    InstrDone = 1'b0;
    Illegal   = 1'b0;

    case (stateQ)
      sIdle: stateNext = sFetch;

      sFetch: begin
        MemRead = 1'b1;
        if (MemReady) begin
          IrWrite   = 1'b1;
          PcWrite   = 1'b1;
          stateNext = sDecode;
        end
      end

      sDecode: begin
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        stateNext = isDefined(OPCODE) ? sExec : sTrap;
`else
        // Undefined opcodes fall through EXEC as a NOP.
        stateNext = sExec;
`endif
      end

      sExec: begin
        case (opQ)
          opR: begin
            RegDst    = 1'b1;
            AluOp     = 2'b10;
            stateNext = sWb;
          end
          opMul: begin
            RegDst    = 1'b1;
            AluOp     = 2'b11;
            stateNext = sWb;
          end
          opAddi: begin
            AluSrc    = 1'b1;
            stateNext = sWb;
          end
          opLs, opSs: begin
            AluSrc    = 1'b1;
            stateNext = sMem;
          end
          opBeq: begin
            Branch    = 1'b1;
            AluOp     = 2'b01;
            PcSrc     = 1'b1;
            PcWrite   = Zero;
            InstrDone = 1'b1;
            stateNext = sFetch;
          end
          default: begin
            InstrDone = 1'b1;
            stateNext = sFetch;
          end
        endcase
      end

      sMem: begin
        case (opQ)
          opLs: begin
            MemRead = 1'b1;
            AluSrc  = 1'b1;
            if (MemReady) stateNext = sWb;
          end
          opSs: begin
            MemWrite = 1'b1;
            AluSrc   = 1'b1;
            if (MemReady) begin
              InstrDone = 1'b1;
              stateNext = sFetch;
            end
          end
          default: stateNext = sFetch;
        endcase
      end

      sWb: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        MemToReg  = (opQ == opLs);
        RegDst    = (opQ == opR) || (opQ == opMul);
        stateNext = sFetch;
      end

      sTrap: begin
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        Illegal   = 1'b1;
        stateNext = sTrap;
`else
        stateNext = sIdle;
`endif
      end

      default: stateNext = sIdle;
    endcase
  end

  assign State = stateQ;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - randomized self-checking bench for cpu_sequencer
// Honours CPU_SEQ_ILLEGAL_TRAP_EN when defined for the build.
module tb_cpu_sequencer;

  localparam int CW = 8;

  logic          Clock, Reset, Zero, MemReady;
  logic [3:0]    OPCODE;
  logic          PcWrite, IrWrite, PcSrc, RegDst, Branch, MemRead, MemToReg;
  logic          MemWrite, AluSrc, RegWrite, InstrDone, Illegal;
  logic [1:0]    AluOp;
  logic [2:0]    State;
  logic [CW-1:0] RetiredCount;

  cpu_sequencer #(.CNT_W(CW)) dut (
    .Clock(Clock), .Reset(Reset), .OPCODE(OPCODE), .Zero(Zero), .MemReady(MemReady),
    .PcWrite(PcWrite), .IrWrite(IrWrite), .PcSrc(PcSrc), .RegDst(RegDst),
    .Branch(Branch), .MemRead(MemRead), .MemToReg(MemToReg), .MemWrite(MemWrite),
    .AluSrc(AluSrc), .RegWrite(RegWrite), .AluOp(AluOp), .InstrDone(InstrDone),
    .Illegal(Illegal), .State(State), .RetiredCount(RetiredCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic [16:0] obs;
  assign obs = {State, PcWrite, IrWrite, PcSrc, RegDst, Branch, MemRead, MemToReg,
                MemWrite, AluSrc, RegWrite, AluOp, InstrDone, Illegal};

  localparam logic [16:0] kPcw  = 17'd1 << 13;
  localparam logic [16:0] kIrw  = 17'd1 << 12;
  localparam logic [16:0] kPcs  = 17'd1 << 11;
  localparam logic [16:0] kRd   = 17'd1 << 10;
  localparam logic [16:0] kBr   = 17'd1 << 9;
  localparam logic [16:0] kMrd  = 17'd1 << 8;
  localparam logic [16:0] kM2r  = 17'd1 << 7;
  localparam logic [16:0] kMw   = 17'd1 << 6;
  localparam logic [16:0] kAs   = 17'd1 << 5;
  localparam logic [16:0] kRw   = 17'd1 << 4;
  localparam logic [16:0] kDone = 17'd1 << 1;
  localparam logic [16:0] kIll  = 17'd1;

  typedef struct {
    logic        mr;
    logic        dec;
    logic [16:0] exp;
  } stepT;

  stepT          plan[$];
  int            vecs = 0;
  int            errs = 0;
  logic [CW-1:0] cnt = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] st(input int s);
    logic [16:0] t;
    t = 17'(s);
    return t << 14;
  endfunction

  function automatic logic [16:0] aop(input int a);
    logic [16:0] t;
    t = 17'(a);
    return t << 2;
  endfunction

  function automatic logic rb();
    return $urandom_range(0, 1) != 0;
  endfunction

  function automatic logic definedOp(input logic [3:0] op);
    return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7};
  endfunction

  task automatic add(input logic mr, input logic dec, input logic [16:0] e);
    stepT s;
    s.mr  = mr;
    s.dec = dec;
    s.exp = e;
    plan.push_back(s);
  endtask

  // Build the expected per-cycle control trace of one instruction from the
  // opcode rules, then replay it against the DUT. abortIdx >= 0 asserts Reset
  // right after that step has been checked.
  task automatic runOp(input logic [3:0] op, input int fs, input int ms, input logic z,
                       input int abortIdx);
    logic trapped;
    trapped = 1'b0;
    plan.delete();
    for (int i = 0; i < fs; i++) add(1'b0, 1'b0, st(1) | kMrd);
    add(1'b1, 1'b0, st(1) | kMrd | kIrw | kPcw);
    add(rb(), 1'b1, st(2));
    case (op)
      4'd1: begin
        add(rb(), 1'b0, st(3) | kAs);
        add(rb(), 1'b0, st(5) | kRw | kDone);
      end
      4'd6, 4'd7: begin
        add(rb(), 1'b0, st(3) | kRd | aop(op == 4'd6 ? 2 : 3));
        add(rb(), 1'b0, st(5) | kRw | kRd | kDone);
      end
      4'd2: begin
        add(rb(), 1'b0, st(3) | kAs);
        for (int i = 0; i < ms; i++) add(1'b0, 1'b0, st(4) | kMrd | kAs);
        add(1'b1, 1'b0, st(4) | kMrd | kAs);
        add(rb(), 1'b0, st(5) | kM2r | kRw | kDone);
      end
      4'd3: begin
        add(rb(), 1'b0, st(3) | kAs);
        for (int i = 0; i < ms; i++) add(1'b0, 1'b0, st(4) | kMw | kAs);
        add(1'b1, 1'b0, st(4) | kMw | kAs | kDone);
      end
      4'd4: add(rb(), 1'b0, st(3) | kBr | aop(1) | kPcs | (z ? kPcw : 17'd0) | kDone);
      default: begin
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        if (definedOp(op)) begin
          add(rb(), 1'b0, st(3) | kDone);
        end else begin
          trapped = 1'b1;
          for (int i = 0; i < 100; i++) add(rb(), 1'b0, st(7) | kIll);
        end
`else
        add(rb(), 1'b0, st(3) | kDone);
`endif
      end
    endcase

    for (int i = 0; i < plan.size(); i++) begin
      @(negedge Clock);
      MemReady = plan[i].mr;
      Zero     = z;
      OPCODE   = plan[i].dec ? op : 4'($urandom_range(0, 15));
      #1;
      chk("ctl", 32'(obs), 32'(plan[i].exp));
      if (i == abortIdx) begin
        Reset = 1'b1;
        #1;
        chk("abort_regwrite", 32'(RegWrite), 32'd0);
        chk("abort_state", 32'(State), 32'd0);
        chk("abort_count", 32'(RetiredCount), 32'd0);
        cnt = '0;
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        chk("release_idle", 32'(obs), 32'd0);
        @(posedge Clock);
        #1;
        chk("release_memread", 32'(MemRead), 32'd1);
        chk("release_state", 32'(State), 32'd1);
        return;
      end
    end
    @(posedge Clock);
    #1;
    if (!trapped) cnt++;
    chk("retired", 32'(RetiredCount), 32'(cnt));
  endtask

  initial begin
    logic [3:0] op;
    Reset    = 1'b1;
    OPCODE   = 4'd0;
    Zero     = 1'b0;
    MemReady = 1'b1;
    repeat (2) @(negedge Clock);
    #1;
    chk("reset_ctl", 32'(obs), 32'd0);
    chk("reset_count", 32'(RetiredCount), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    chk("idle_ctl", 32'(obs), 32'd0);

    runOp(4'd1, 0, 0, 1'b0, -1);
    runOp(4'd1, 0, 0, 1'b0, 3);
    runOp(4'd1, 0, 0, 1'b0, -1);
    runOp(4'd2, 0, 2, 1'b0, -1);
    runOp(4'd4, 0, 0, 1'b1, -1);
    runOp(4'd4, 0, 0, 1'b0, -1);
    runOp(4'd3, 0, 0, 1'b0, -1);
    runOp(4'd6, 1, 0, 1'b0, -1);
    runOp(4'd7, 0, 0, 1'b1, -1);
    runOp(4'd0, 2, 0, 1'b0, -1);

    for (int n = 0; n < 300; n++) begin
      op = 4'($urandom_range(0, 15));
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
      while (!definedOp(op)) op = 4'($urandom_range(0, 15));
`endif
      runOp(op,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
            ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0,
            rb(), -1);
    end

    while (cnt != '1) runOp(4'd0, 0, 0, 1'b0, -1);
    runOp(4'd3, 0, 0, 1'b0, -1);
    chk("count_wrap", 32'(RetiredCount), 32'd0);

    runOp(4'b1010, 0, 0, 1'b0, -1);
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
    Reset = 1'b1;
    #1;
    chk("trap_reset_illegal", 32'(Illegal), 32'd0);
    chk("trap_reset_state", 32'(State), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
